// File: rtl/q100_pkg.sv
// Shared types for the q100 load/store unit: access sizes and FSM states.
package q100_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2,
        RSVD = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RSP  = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/q100_lsu_lane.sv
// Combinational lane steering: store data replication, byte-enable generation,
// and load lane select with sign/zero extension.
module q100_lsu_lane
    import q100_pkg::*;
#(
    parameter int DTCM_DATA_WIDTH = 32,
    parameter int DTCM_BANK       = 4,
    parameter int LANE_W          = $clog2(DTCM_BANK)
) (
    input  lsu_size_e                  st_size,
    input  logic [LANE_W-1:0]          st_lane,
    input  logic [31:0]                st_wdata,
    output logic [DTCM_DATA_WIDTH-1:0] wdata_rep,
    output logic [DTCM_BANK-1:0]       byte_en,
    input  lsu_size_e                  ld_size,
    input  logic [LANE_W-1:0]          ld_lane,
    input  logic                       ld_unsigned,
    input  logic [DTCM_DATA_WIDTH-1:0] ld_word,
    output logic [31:0]                ld_data
);

    logic [DTCM_BANK-1:0]       be_base;
    logic [DTCM_DATA_WIDTH-1:0] shifted;
    logic [31:0]                sel;

    always_comb begin
        wdata_rep = '0;
        for (int i = 0; i < DTCM_BANK; i++) begin
            case (st_size)
                BYTE:    wdata_rep[8*i +: 8] = st_wdata[7:0];
                HALF:    wdata_rep[8*i +: 8] = st_wdata[8*(i%2) +: 8];
                default: wdata_rep[8*i +: 8] = st_wdata[8*(i%4) +: 8];
            endcase
        end
    end

    // The lane index is already naturally aligned by the caller, so a plain shift suffices.
    always_comb begin
        case (st_size)
            BYTE:    be_base = DTCM_BANK'(4'b0001);
            HALF:    be_base = DTCM_BANK'(4'b0011);
            WORD:    be_base = DTCM_BANK'(4'b1111);
            default: be_base = '0;
        endcase
        byte_en = be_base << st_lane;
    end

    always_comb begin
        shifted = ld_word >> {ld_lane, 3'b000};
        sel     = shifted[31:0];
        case (ld_size)
            BYTE:    ld_data = {{24{~ld_unsigned & sel[7]}}, sel[7:0]};
            HALF:    ld_data = {{16{~ld_unsigned & sel[15]}}, sel[15:0]};
            WORD:    ld_data = sel;
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/q100_lsu.sv
// Single-outstanding load/store unit in front of a 1-cycle-latency DTCM.
// Define Q100_LSU_MISALIGN_EXC_EN to fault misaligned accesses instead of force-aligning them.
module q100_lsu
    import q100_pkg::*;
#(
    parameter int DTCM_DATA_WIDTH = 32,
    parameter int DTCM_ADDR_WIDTH = 12,
    parameter int DTCM_BANK       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    // req: accepted when req_valid && req_ready; req_ready is high only in IDLE.
    // rsp: rsp_valid/rsp_rdata/rsp_err hold until rsp_valid && rsp_ready.
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [1:0]                 req_size,
    input  logic                       req_unsigned,
    input  logic [DTCM_ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]                req_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [31:0]                rsp_rdata,
    output logic                       rsp_err,
    output logic [DTCM_ADDR_WIDTH-1:0] dtcm_addr_o,
    output logic [DTCM_BANK-1:0]       dtcm_we_o,
    output logic [DTCM_DATA_WIDTH-1:0] dtcm_wdata_o,
    input  logic [DTCM_DATA_WIDTH-1:0] dtcm_rdata_i,
    output lsu_state_e                 dbg_state
);

    localparam int LANE_W = $clog2(DTCM_BANK);

    lsu_state_e                 state_q, state_d;
    lsu_size_e                  req_size_e, size_q;
    logic [DTCM_ADDR_WIDTH-1:0] eff_addr, addr_q;
    logic                       uns_q;
    logic                       accept, acc_err;
    logic [DTCM_BANK-1:0]       byte_en;
    logic [31:0]                ld_data;

    assign req_size_e = lsu_size_e'(req_size);

    always_comb begin
        eff_addr = req_addr;
        case (req_size_e)
            HALF:    eff_addr[0]   = 1'b0;
            WORD:    eff_addr[1:0] = 2'b00;
            default: eff_addr      = req_addr;
        endcase
    end

`ifdef Q100_LSU_MISALIGN_EXC_EN
    logic misalign;
    assign misalign = (req_size_e == HALF && req_addr[0]) ||
                      (req_size_e == WORD && req_addr[1:0] != 2'b00);
    assign acc_err  = (req_size_e == RSVD) || misalign;
`else
    assign acc_err  = (req_size_e == RSVD);
`endif

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == RSP) && !rst;
    assign dbg_state = state_q;

    // Outside IDLE the registered address stays on the bus; it is harmless since writes only occur at accept.
    assign dtcm_addr_o = (state_q == IDLE) ? eff_addr : addr_q;
    assign dtcm_we_o   = (accept && req_we && !acc_err) ? byte_en : '0;

    q100_lsu_lane #(
        .DTCM_DATA_WIDTH(DTCM_DATA_WIDTH),
        .DTCM_BANK      (DTCM_BANK)
    ) u_lane (
        .st_size    (req_size_e),
        .st_lane    (eff_addr[LANE_W-1:0]),
        .st_wdata   (req_wdata),
        .wdata_rep  (dtcm_wdata_o),
        .byte_en    (byte_en),
        .ld_size    (size_q),
        .ld_lane    (addr_q[LANE_W-1:0]),
        .ld_unsigned(uns_q),
        .ld_word    (dtcm_rdata_i),
        .ld_data    (ld_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (acc_err || req_we) ? RSP : LOAD;
            LOAD:    state_d = RSP;
            RSP:     if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            size_q    <= BYTE;
            uns_q     <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q    <= eff_addr;
                size_q    <= req_size_e;
                uns_q     <= req_unsigned;
                rsp_rdata <= '0;
                rsp_err   <= acc_err;
            end
            if (state_q == LOAD) rsp_rdata <= ld_data;
        end
    end

endmodule

// File: tb/tb_q100_lsu.sv
// Bench for q100_lsu: directed scenarios plus random traffic against a byte-array memory model.
module tb_q100_lsu;
    import q100_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [11:0] dtcm_addr_o;
    logic [3:0]  dtcm_we_o;
    logic [31:0] dtcm_wdata_o;
    logic [31:0] dtcm_rdata_i;
    lsu_state_e  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_err_q[$];
    logic [7:0]  ref_mem[0:4095];
    logic [31:0] dtcm[0:1023];
    logic        mem_init;

    q100_lsu dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .dtcm_addr_o (dtcm_addr_o),
        .dtcm_we_o   (dtcm_we_o),
        .dtcm_wdata_o(dtcm_wdata_o),
        .dtcm_rdata_i(dtcm_rdata_i),
        .dbg_state   (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int w);
        return (32'(w) * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
    endfunction

    // DTCM responder: byte-lane writes, read data one cycle after address
    always @(posedge clk) begin
        if (mem_init) begin
            for (int w = 0; w < 1024; w++) dtcm[w] <= init_word(w);
        end else begin
            for (int b = 0; b < 4; b++)
                if (dtcm_we_o[b]) dtcm[dtcm_addr_o[11:2]][8*b +: 8] <= dtcm_wdata_o[8*b +: 8];
        end
        dtcm_rdata_i <= dtcm[dtcm_addr_o[11:2]];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Driver + reference: enter at a negedge, leave at a negedge with the unit idle again.
    task automatic do_txn(input logic we, input logic [1:0] size, input logic uns,
                          input logic [11:0] addr, input logic [31:0] wdata,
                          input int hold, input string tag);
        int          n;
        int          lat;
        int          exp_lat;
        logic        err;
        logic [11:0] ea;
        logic [3:0]  exp_we;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        logic [31:0] mask;
        logic [31:0] got_exp;
        logic [31:0] got_err;

        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
`ifdef Q100_LSU_MISALIGN_EXC_EN
        err = (size == 2'd3) || ((int'(addr) % n) != 0);
        ea  = addr;
`else
        err = (size == 2'd3);
        ea  = 12'(int'(addr) - (int'(addr) % n));
`endif
        exp_we = '0;
        exp_wd = '0;
        exp_rd = '0;
        for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wdata[8*(i % n) +: 8];
        if (!err && we) begin
            for (int i = 0; i < n; i++) begin
                exp_we = exp_we | (4'b0001 << ((int'(ea) % 4) + i));
                ref_mem[int'(ea) + i] = wdata[8*i +: 8];
            end
        end else if (!err) begin
            for (int i = 0; i < n; i++) exp_rd = exp_rd | (32'(ref_mem[int'(ea) + i]) << (8*i));
            mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 32'd1);
            if (!uns && n < 4 && exp_rd[8*n-1]) exp_rd = exp_rd | ~mask;
        end
        exp_lat = (err || we) ? 1 : 2;
        exp_q.push_back(exp_rd);
        exp_err_q.push_back({31'd0, err});

        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        rsp_ready    = 1'b0;
        #1;
        check_eq({tag, "/req_ready"}, 32'(req_ready), 32'd1);
        check_eq({tag, "/we_accept"}, 32'(dtcm_we_o), 32'(exp_we));
        check_eq({tag, "/addr_word"}, 32'(dtcm_addr_o[11:2]), 32'(ea[11:2]));
        if (exp_we != 4'd0) check_eq({tag, "/wdata"}, dtcm_wdata_o, exp_wd);

        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = 12'($urandom);
        req_wdata    = $urandom;

        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            check_eq({tag, "/we_busy"}, 32'(dtcm_we_o), 32'd0);
        end while (!rsp_valid && lat < 8);
        check_eq({tag, "/latency"}, 32'(lat), 32'(exp_lat));

        got_exp = exp_q.pop_front();
        got_err = exp_err_q.pop_front();
        check_eq({tag, "/rdata"}, rsp_rdata, got_exp);
        check_eq({tag, "/err"}, 32'(rsp_err), got_err);

        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check_eq({tag, "/hold_valid"}, 32'(rsp_valid), 32'd1);
            check_eq({tag, "/hold_rdata"}, rsp_rdata, got_exp);
            check_eq({tag, "/hold_err"}, 32'(rsp_err), got_err);
            check_eq({tag, "/hold_ready"}, 32'(req_ready), 32'd0);
        end

        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check_eq({tag, "/rsp_done"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "/idle_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        mem_init     = 1'b1;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        rsp_ready    = 1'b0;
        for (int w = 0; w < 1024; w++)
            for (int b = 0; b < 4; b++) ref_mem[4*w + b] = init_word(w)[8*b +: 8];

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("rst/req_ready", 32'(req_ready), 32'd0);
            check_eq("rst/rsp_valid", 32'(rsp_valid), 32'd0);
            check_eq("rst/we", 32'(dtcm_we_o), 32'd0);
        end
        mem_init = 1'b0;
        rst      = 1'b0;
        #1;
        check_eq("rst/ready_after", 32'(req_ready), 32'd1);
        check_eq("rst/rdata", rsp_rdata, 32'd0);
        check_eq("rst/err", 32'(rsp_err), 32'd0);
        check_eq("rst/state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);

        do_txn(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEAD_BEEF, 0, "st_word");
        do_txn(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 0, "ld_word");
        do_txn(1'b1, 2'd0, 1'b0, 12'h013, 32'h0000_0080, 0, "st_byte");
        do_txn(1'b0, 2'd0, 1'b0, 12'h013, 32'h0, 1, "ld_byte_s");
        do_txn(1'b0, 2'd0, 1'b1, 12'h013, 32'h0, 0, "ld_byte_u");
        do_txn(1'b1, 2'd1, 1'b0, 12'h022, 32'h0000_8001, 0, "st_half");
        do_txn(1'b0, 2'd1, 1'b0, 12'h022, 32'h0, 0, "ld_half_s");
        do_txn(1'b0, 2'd2, 1'b0, 12'h011, 32'h0, 0, "ld_misalign");
        do_txn(1'b1, 2'd1, 1'b0, 12'h035, 32'h1234_5678, 0, "st_half_mis");
        do_txn(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 5, "ld_hold5");
        do_txn(1'b1, 2'd3, 1'b0, 12'h000, 32'hFFFF_FFFF, 2, "st_rsvd");
        do_txn(1'b0, 2'd3, 1'b1, 12'h004, 32'h0, 0, "ld_rsvd");

        // Reset while a load sits in LOAD: the access must vanish without a response.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'd2;
        req_addr  = 12'h010;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check_eq("rst_load/in_load", 32'(dbg_state), 32'(LOAD));
        @(negedge clk);
        check_eq("rst_load/state", 32'(dbg_state), 32'(IDLE));
        check_eq("rst_load/rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_load/req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_load/rdata", rsp_rdata, 32'd0);
        check_eq("rst_load/err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("rst_load/no_rsp", 32'(rsp_valid), 32'd0);
            check_eq("rst_load/ready", 32'(req_ready), 32'd1);
        end

        for (int t = 0; t < 300; t++)
            do_txn(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), 12'($urandom),
                   $urandom, $urandom_range(0, 3), "rand");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/q100_lsu.md
Q100_LSU -- requirements
Module: q100_lsu

Interface
REQ-001 SHALL have parameter DTCM_DATA_WIDTH, default 32, DTCM data bus width (= 8*DTCM_BANK).
REQ-002 SHALL have parameter DTCM_ADDR_WIDTH, default 12, byte address width.
REQ-003 SHALL have parameter DTCM_BANK, default 4, byte lanes per word.
REQ-004 SHALL have ports: clk  in  1  sole clock; rst  in  1  synchronous active-high reset (one clock; reset is synchronous and active-high).
REQ-005 SHALL have ports: req_valid in 1; req_ready out 1; req_we in 1 (1=store); req_size in 2 (0 byte, 1 half, 2 word, 3 reserved); req_unsigned in 1 (zero-extend loads); req_addr in DTCM_ADDR_WIDTH byte address; req_wdata in 32 store data, right-justified.
REQ-006 SHALL have ports: rsp_valid out 1; rsp_ready in 1; rsp_rdata out 32 extended load data; rsp_err out 1 access fault.
REQ-007 SHALL have ports: dtcm_addr_o out DTCM_ADDR_WIDTH; dtcm_we_o out DTCM_BANK byte write enables; dtcm_wdata_o out DTCM_DATA_WIDTH; dtcm_rdata_i in DTCM_DATA_WIDTH, valid one cycle after address presented.

Function
REQ-008 SHALL use FSM states IDLE, LOAD (read-data capture), RSP (response hold).
REQ-009 SHALL assert req_ready only in IDLE; accept = req_valid && req_ready.
REQ-010 SHALL drive dtcm_addr_o = req_addr and dtcm_wdata_o combinationally in IDLE; dtcm_we_o nonzero only in the accept cycle of an error-free store.
REQ-011 SHALL replicate store data: byte to all 4 lanes, half to both halves, word as-is.
REQ-012 SHALL set dtcm_we_o: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-013 Store accept SHALL go IDLE->RSP; rsp_valid high cycle after accept, rsp_rdata=0.
REQ-014 Load accept SHALL go IDLE->LOAD->RSP; in LOAD, select lane by registered addr[1:0]/size, sign- or zero-extend per req_unsigned, register into rsp_rdata; rsp_valid high two cycles after accept.
REQ-015 In RSP, rsp_valid, rsp_rdata, rsp_err SHALL hold stable until rsp_ready; on rsp_valid&&rsp_ready go to IDLE (next accept earliest following cycle).
REQ-016 req_size=3 SHALL produce rsp_err=1, no write, IDLE->RSP, regardless of configuration.
REQ-017 Address/size/unsigned SHALL be registered at accept; later req_* changes SHALL not affect an in-flight access.

Reset
REQ-018 rst SHALL force state IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, dtcm_we_o=0 in the same cycle, aborting any in-flight access.
REQ-019 req_ready SHALL be 0 while rst is high and 1 the first cycle after rst deasserts.

Configuration
REQ-020 With Q100_LSU_MISALIGN_EXC_EN defined, misaligned half (addr[0]=1) or word (addr[1:0]!=0) SHALL be rejected: no write, no load data, IDLE->RSP with rsp_err=1, rsp_rdata=0.
REQ-021 Without Q100_LSU_MISALIGN_EXC_EN, low address bits SHALL be forced to natural alignment (half clears bit0, word clears bits1:0), access performed, rsp_err=0.

Structure
REQ-022 q100_pkg SHALL hold lsu_size_e (BYTE/HALF/WORD/RSVD) and the lsu_state_e FSM typedef.
REQ-023 Lane steering and extension SHALL be sub-module q100_lsu_lane (combinational: wdata replicate, byte-enable generate, rdata select/extend); FSM stays in q100_lsu.

Verification
REQ-024 Store word 0xDEADBEEF @0x010, then load word @0x010 -> dtcm_we_o=4'b1111 on accept; rsp_rdata=0xDEADBEEF two cycles after load accept.
REQ-025 Store byte 0x80 @0x013; load byte signed @0x013 -> 0xFFFFFF80; unsigned -> 0x00000080; dtcm_we_o=4'b1000.
REQ-026 Store half 0x8001 @0x022; load half signed -> 0xFFFF8001; we=4'b1100, wdata=0x80018001.
REQ-027 Load word @0x011 -> with macro rsp_err=1, no write; without macro returns word @0x010, rsp_err=0.
REQ-028 rsp_ready held low 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0; rst asserted in LOAD -> next cycle IDLE, rsp_valid=0, no response emitted.
REQ-029 req_size=3 store @0x000 -> rsp_err=1, dtcm_we_o=0 every cycle.
